// File: rtl/counter_readout_sched_pkg.sv
// Shared types and constants for the timestamp counter readout scheduler.
//   state_e   : readout FSM states, IDLE through WAIT
//   CH1/CH2   : channel encodings; this is also the header channel bit
//   HDR_*     : header word field positions
//   make_hdr  : assembles a header word from tag, channel and sequence number
package counter_readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_HDR,
        ST_LO,
        ST_HI,
        ST_PH,
        ST_CLR,
        ST_WAIT
    } state_e;

    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;

    localparam int HDR_TAG_MSB = 31;
    localparam int HDR_TAG_LSB = 24;
    localparam int HDR_CH_BIT  = 16;
    localparam int HDR_SEQ_MSB = 15;

    function automatic logic [31:0] make_hdr(input logic [7:0] tag, input logic ch,
                                             input logic [15:0] seq);
        logic [31:0] h;
        h = '0;
        h[HDR_TAG_MSB:HDR_TAG_LSB] = tag;
        h[HDR_CH_BIT]              = ch;
        h[HDR_SEQ_MSB:0]           = seq;
        return h;
    endfunction

endpackage

// File: rtl/counter_readout_sched_if.sv
// Host word stream (valid/ready) carrying readout frames.
//   oData  : 32-bit stream word           (master -> slave)
//   oValid : word valid                   (master -> slave)
//   oLast  : final word of a frame        (master -> slave)
//   iReady : host accepts the word        (slave -> master)
interface counter_readout_sched_if;
    logic [31:0] oData;
    logic        oValid;
    logic        oLast;
    logic        iReady;

    modport master (output oData, oValid, oLast, input iReady);
    modport slave  (input oData, oValid, oLast, output iReady);
endinterface

// File: rtl/counter_readout_sched_rdy_sync.sv
// Synchroniser for one asynchronous channel ready flag.
//   globalClock : destination clock
//   iRstN       : asynchronous active-low reset, clears the chain
//   iRdy        : asynchronous ready flag
//   oRdyS       : iRdy delayed through pSYNC flops
module rdy_sync #(
    parameter int pSYNC = 2
) (
    input  logic globalClock,
    input  logic iRstN,
    input  logic iRdy,
    output logic oRdyS
);
    logic [pSYNC-1:0] chain_q;

    always_ff @(posedge globalClock or negedge iRstN) begin
        if (!iRstN) chain_q <= '0;
        else        chain_q <= {chain_q[pSYNC-2:0], iRdy};
    end

    assign oRdyS = chain_q[pSYNC-1];
endmodule

// File: rtl/counter_readout_sched.sv
// Readout scheduler for the two latch channels of the 64-bit timestamp counter.
// Arbitrates the synchronised ready flags round-robin, snapshots {lo,hi,phase},
// sends a 4-word frame (header, lo, hi, phase) on the host stream, pulses the
// channel's reset-latch and waits for its ready flag to drop.
//   globalClock, iRstN          : clock, asynchronous active-low reset
//   iEnable                     : allow new grants (current frame always completes)
//   iRdy1/iRdy2                 : asynchronous channel ready flags
//   i1Lo/i1Hi/i1Ph, i2Lo/...    : channel latched words, stable while ready is high
//   oResetLatch1/2              : single-cycle reset-latch pulse
//   strm                        : host word stream (master side)
//   oBusy                       : FSM not idle
//   oErr                        : sticky clear-timeout flag
import counter_readout_pkg::*;

module counter_readout_sched #(
    parameter int         pSYNC    = 2,
    parameter int         pCLR_TMO = 1024,
    parameter logic [7:0] pTAG     = 8'hC7
) (
    input  logic        globalClock,
    input  logic        iRstN,
    input  logic        iEnable,
    input  logic        iRdy1,
    input  logic        iRdy2,
    input  logic [31:0] i1Lo,
    input  logic [31:0] i1Hi,
    input  logic [31:0] i1Ph,
    input  logic [31:0] i2Lo,
    input  logic [31:0] i2Hi,
    input  logic [31:0] i2Ph,
    output logic        oResetLatch1,
    output logic        oResetLatch2,
    counter_readout_sched_if.master strm,
    output logic        oBusy,
    output logic        oErr
);
    localparam int TW = $clog2(pCLR_TMO + 1);

    state_e        state_q, state_d;
    logic          rr_q, rr_d;       // channel preferred when both are eligible
    logic          gnt_q, gnt_d;     // channel owning the current frame
    logic [1:0]    mask_q, mask_d;   // channels blocked after a clear timeout
    logic [15:0]   seq_q, seq_d;
    logic [31:0]   lo_q, lo_d, hi_q, hi_d, ph_q, ph_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [1:0]    rdy_s;
    logic [1:0]    elig;
    logic          acc;

    rdy_sync #(.pSYNC(pSYNC)) u_sync1 (
        .globalClock(globalClock), .iRstN(iRstN), .iRdy(iRdy1), .oRdyS(rdy_s[0])
    );
    rdy_sync #(.pSYNC(pSYNC)) u_sync2 (
        .globalClock(globalClock), .iRstN(iRstN), .iRdy(iRdy2), .oRdyS(rdy_s[1])
    );

    assign elig  = rdy_s & ~mask_q;
    assign acc   = strm.oValid && strm.iReady;
    assign oBusy = (state_q != ST_IDLE);
    assign oErr  = err_q;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        mask_d       = mask_q & rdy_s;   // a mask lifts once the flag is seen low
        seq_d        = seq_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        ph_d         = ph_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        strm.oValid  = 1'b0;
        strm.oData   = '0;
        strm.oLast   = 1'b0;
        oResetLatch1 = 1'b0;
        oResetLatch2 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iEnable && (elig != 2'b00)) begin
                    state_d = ST_SNAP;
                    if (&elig) begin
                        gnt_d = rr_q;
                        rr_d  = ~rr_q;
                    end else begin
                        gnt_d = elig[1] ? CH2 : CH1;
                    end
                end
            end
            ST_SNAP: begin
                lo_d    = (gnt_q == CH2) ? i2Lo : i1Lo;
                hi_d    = (gnt_q == CH2) ? i2Hi : i1Hi;
                ph_d    = (gnt_q == CH2) ? i2Ph : i1Ph;
                state_d = ST_HDR;
            end
            ST_HDR: begin
                strm.oValid = 1'b1;
                strm.oData  = make_hdr(pTAG, gnt_q, seq_q);
                if (acc) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                strm.oValid = 1'b1;
                strm.oData  = lo_q;
                if (acc) state_d = ST_HI;
            end
            ST_HI: begin
                strm.oValid = 1'b1;
                strm.oData  = hi_q;
                if (acc) state_d = ST_PH;
            end
            ST_PH: begin
                strm.oValid = 1'b1;
                strm.oData  = ph_q;
                strm.oLast  = 1'b1;
                if (acc) state_d = ST_CLR;
            end
            ST_CLR: begin
                oResetLatch1 = (gnt_q == CH1);
                oResetLatch2 = (gnt_q == CH2);
                tmo_d        = '0;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (!rdy_s[gnt_q]) begin
                    state_d = ST_IDLE;
                end else if (tmo_q == TW'(pCLR_TMO - 1)) begin
                    // Flag never dropped: flag the error and keep the channel out
                    // of arbitration until it is observed low.
                    err_d         = 1'b1;
                    mask_d[gnt_q] = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge globalClock or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            rr_q    <= CH1;
            gnt_q   <= CH1;
            mask_q  <= '0;
            seq_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ph_q    <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            mask_q  <= mask_d;
            seq_q   <= seq_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ph_q    <= ph_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_counter_readout_sched.sv
`timescale 1ns/1ps
module tb_counter_readout_sched;
    localparam int SYNC = 2;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rdy [2];
    logic [31:0] lo [2];
    logic [31:0] hi [2];
    logic [31:0] ph [2];
    logic        rl1, rl2, busy, err;

    counter_readout_sched_if strm();

    counter_readout_sched #(.pSYNC(SYNC), .pCLR_TMO(TMO), .pTAG(8'hC7)) dut (
        .globalClock(clk), .iRstN(rst_n), .iEnable(en),
        .iRdy1(rdy[0]), .iRdy2(rdy[1]),
        .i1Lo(lo[0]), .i1Hi(hi[0]), .i1Ph(ph[0]),
        .i2Lo(lo[1]), .i2Hi(hi[1]), .i2Ph(ph[1]),
        .oResetLatch1(rl1), .oResetLatch2(rl2),
        .strm(strm), .oBusy(busy), .oErr(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counter block behaviour plus expected frame contents.
    bit          pend [2];       // channel raised ready and awaits its frame
    int          drop_cnt [2];   // cycles until the counter block drops ready
    int          low_cnt [2];
    bit          hold [2];       // counter block ignores the reset-latch pulse
    bit          auto_raise = 0;
    bit          auto_en = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    logic [31:0] fw [4];
    int          widx = 0;
    logic [15:0] exp_seq = 16'd0;
    int          frames = 0;
    int          last_ch = 0;
    bit          exp_clr = 0;
    int          pulses = 0;
    int          ch_log [$];
    logic [31:0] word_log [$];
    bit          prev_stall = 0;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic raise(input int ch, input logic [31:0] l, input logic [31:0] h,
                         input logic [31:0] p);
        lo[ch] = l; hi[ch] = h; ph[ch] = p;
        rdy[ch] = 1'b1; pend[ch] = 1'b1; low_cnt[ch] = 0;
    endtask

    task automatic check_frame();
        int ch;
        ch = int'(fw[0][16]);
        chk("hdr_tag", 32'(fw[0][31:24]), 32'hC7);
        chk("hdr_zero", 32'(fw[0][23:17]), 32'h0);
        chk("hdr_seq", 32'(fw[0][15:0]), 32'(exp_seq));
        chk("pending", 32'(pend[ch]), 32'd1);
        chk("lo", fw[1], lo[ch]);
        chk("hi", fw[2], hi[ch]);
        chk("ph", fw[3], ph[ch]);
        chk("clr_missing", 32'(exp_clr), 32'd0);
        exp_seq = exp_seq + 16'd1;
        pend[ch] = 1'b0;
        last_ch = ch;
        exp_clr = 1'b1;
        ch_log.push_back(ch);
        frames++;
    endtask

    task automatic monitor();
        int ch;
        if (prev_stall) begin
            chk("stall_valid", 32'(strm.oValid), 32'd1);
            chk("stall_data", strm.oData, prev_data);
            chk("stall_last", 32'(strm.oLast), 32'(prev_last));
        end
        prev_stall = strm.oValid && !strm.iReady;
        prev_data  = strm.oData;
        prev_last  = strm.oLast;
        if (strm.oValid && strm.iReady) begin
            fw[widx] = strm.oData;
            word_log.push_back(strm.oData);
            chk("last_flag", 32'(strm.oLast), 32'(widx == 3));
            if (widx == 3) begin
                check_frame();
                widx = 0;
            end else begin
                widx++;
            end
        end
        if (rl1 || rl2) begin
            chk("clr_one_hot", 32'(rl1 && rl2), 32'd0);
            chk("clr_expected", 32'(exp_clr), 32'd1);
            chk("clr_ch", 32'(rl2), 32'(last_ch));
            exp_clr = 1'b0;
            pulses++;
            ch = rl2 ? 1 : 0;
            if (!hold[ch]) drop_cnt[ch] = $urandom_range(3, 1);
        end
    endtask

    // One clock cycle: drive inputs, observe outputs, advance past the edge.
    task automatic step();
        case (rdy_mode)
            0:       strm.iReady = 1'b1;
            1:       strm.iReady = ($urandom_range(3) != 0);
            2:       strm.iReady = ((cyc % 4) == 0);
            default: strm.iReady = 1'b0;
        endcase
        if (auto_en && $urandom_range(49) == 0) en = ~en;
        for (int ch = 0; ch < 2; ch++) begin
            if (drop_cnt[ch] > 0) begin
                drop_cnt[ch]--;
                if (drop_cnt[ch] == 0) rdy[ch] = 1'b0;
            end else if (!rdy[ch]) begin
                low_cnt[ch]++;
                if (auto_raise && low_cnt[ch] >= 6 && !pend[ch] && $urandom_range(7) == 0)
                    raise(ch, $urandom(), $urandom(), $urandom());
            end
        end
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int n_frames, input int budget, input string tag);
        int k;
        k = 0;
        while ((frames < n_frames || busy) && k < budget) begin
            step();
            k++;
        end
        chk(tag, frames, n_frames);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, k, b, base;
        for (int ch = 0; ch < 2; ch++) begin
            rdy[ch] = 1'b0; lo[ch] = '0; hi[ch] = '0; ph[ch] = '0;
            pend[ch] = 0; drop_cnt[ch] = 0; low_cnt[ch] = 10; hold[ch] = 0;
        end
        strm.iReady = 1'b0;

        // Reset state
        #22;
        chk("rst_valid", 32'(strm.oValid), 32'd0);
        chk("rst_data", strm.oData, 32'd0);
        chk("rst_last", 32'(strm.oLast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_latch", 32'({rl1, rl2}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en = 1'b1;
        repeat (3) step();

        // T1: single ch1 frame, latency and exact words
        raise(0, 32'h1111_0001, 32'h0, 32'h155);
        n = 0;
        while (!strm.oValid && n < 20) begin
            step();
            n++;
        end
        chk("t1_latency", n, SYNC + 2);
        run_until(1, 200, "t1_done");
        chk("t1_w0", word_log[0], 32'hC700_0000);
        chk("t1_w1", word_log[1], 32'h1111_0001);
        chk("t1_w2", word_log[2], 32'h0000_0000);
        chk("t1_w3", word_log[3], 32'h0000_0155);
        chk("t1_pulses", pulses, 1);

        // T2: both channels ready together, twice; round-robin order 1,2 then 2,1
        ch_log.delete();
        repeat (8) step();
        base = frames;
        raise(0, $urandom(), $urandom(), $urandom());
        raise(1, $urandom(), $urandom(), $urandom());
        run_until(base + 2, 400, "t2_pair1");
        repeat (8) step();
        raise(0, $urandom(), $urandom(), $urandom());
        raise(1, $urandom(), $urandom(), $urandom());
        run_until(base + 4, 400, "t2_pair2");
        chk("t2_n", ch_log.size(), 4);
        if (ch_log.size() == 4) begin
            chk("t2_o0", ch_log[0], 0);
            chk("t2_o1", ch_log[1], 1);
            chk("t2_o2", ch_log[2], 1);
            chk("t2_o3", ch_log[3], 0);
        end

        // T3: host ready one cycle in four
        repeat (8) step();
        rdy_mode = 2;
        raise(1, $urandom(), $urandom(), $urandom());
        run_until(frames + 1, 400, "t3_done");
        rdy_mode = 0;

        // T5: sequence wrap
        repeat (8) step();
        force dut.seq_q = 16'hFFFF;
        step();
        release dut.seq_q;
        step();
        exp_seq = 16'hFFFF;
        raise(0, $urandom(), $urandom(), $urandom());
        run_until(frames + 1, 200, "t5_f1");
        repeat (8) step();
        raise(1, $urandom(), $urandom(), $urandom());
        run_until(frames + 1, 200, "t5_f2");
        chk("t5_seq_ffff", 32'(word_log[word_log.size() - 8][15:0]), 32'hFFFF);
        chk("t5_seq_0000", 32'(word_log[word_log.size() - 4][15:0]), 32'h0000);

        // Randomised traffic: random ready, random arrivals, enable toggling
        repeat (8) step();
        rdy_mode = 1;
        auto_raise = 1;
        auto_en = 1;
        repeat (3000) step();
        auto_raise = 0;
        auto_en = 0;
        en = 1'b1;
        k = 0;
        while ((pend[0] || pend[1] || busy) && k < 2000) begin
            step();
            k++;
        end
        chk("rand_drain", 32'({pend[0], pend[1], busy}), 32'd0);
        chk("rand_err", 32'(err), 32'd0);
        rdy_mode = 0;
        repeat (10) step();

        // T4: ready stuck high after the clear pulse
        hold[0] = 1;
        raise(0, $urandom(), $urandom(), $urandom());
        k = 0;
        while (!rl1 && k < 100) begin
            step();
            k++;
        end
        chk("t4_pulse", 32'(rl1), 32'd1);
        n = 0;
        step();
        while (busy && n < 100) begin
            n++;
            step();
        end
        chk("t4_wait_cycles", n, TMO);
        chk("t4_err", 32'(err), 32'd1);
        base = frames;
        b = 0;
        repeat (30) begin
            step();
            if (busy) b++;
        end
        chk("t4_masked", b, 0);
        chk("t4_no_frame", frames, base);
        hold[0] = 0;
        rdy[0] = 1'b0;
        low_cnt[0] = 0;
        repeat (8) step();
        raise(0, $urandom(), $urandom(), $urandom());
        run_until(base + 1, 200, "t4_regrant");
        chk("t4_err_sticky", 32'(err), 32'd1);

        // T6: asynchronous reset while the HI word is on the stream
        repeat (8) step();
        raise(0, $urandom(), $urandom(), $urandom());
        k = 0;
        while (widx < 2 && k < 100) begin
            step();
            k++;
        end
        chk("t6_in_hi", strm.oData, hi[0]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(strm.oValid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_last", 32'(strm.oLast), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        widx = 0;
        exp_seq = 16'd0;
        exp_clr = 0;
        prev_stall = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_until(frames + 1, 200, "t6_frame");
        chk("t6_hdr", word_log[word_log.size() - 4], 32'hC700_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
